// File: rtl/systolic_input_feeder_if.sv
// Bus bundle between the operand-buffer feeder and its surroundings:
// start command, buffer read port, and the word stream toward the skew stage.
`ifndef WORD_WIDTH
`define WORD_WIDTH 64
`endif

interface systolic_input_feeder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                    start_i;
    logic [ADDR_WIDTH-1:0]   base_addr_i;
    logic [ADDR_WIDTH:0]     len_i;
    logic                    rd_en_o;
    logic [ADDR_WIDTH-1:0]   rd_addr_o;
    logic [`WORD_WIDTH-1:0]  rd_data_i;
    logic [`WORD_WIDTH-1:0]  word_o;
    logic                    en_o;
    logic                    busy_o;
    logic                    done_o;

    // Controller / environment side: issues commands, serves buffer reads.
    modport master (
        output start_i, base_addr_i, len_i, rd_data_i,
        input  rd_en_o, rd_addr_o, word_o, en_o, busy_o, done_o
    );

    // Feeder side.
    modport slave (
        input  start_i, base_addr_i, len_i, rd_data_i,
        output rd_en_o, rd_addr_o, word_o, en_o, busy_o, done_o
    );
endinterface

// File: rtl/systolic_input_feeder.sv
// Streams a block of operand words from a synchronous-read buffer toward the
// skew stage, followed by FLUSH_LEN zero words that drain the skew registers.
`ifndef WORD_WIDTH
`define WORD_WIDTH 64
`endif

module systolic_input_feeder #(
    parameter int ADDR_WIDTH = 8,
    parameter int FLUSH_LEN  = 7
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    systolic_input_feeder_if.slave  bus
);
    localparam int CNT_W = $clog2(FLUSH_LEN + 2);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ZERO   = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   LEN_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      FLUSH_LAST = CNT_W'(FLUSH_LEN);

    logic [2:0]              state_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH:0]     remain_r;     // reads still to issue after the current one
    logic [CNT_W-1:0]        flush_cnt_r;
    logic                    rd_en_r;
    logic                    valid_r;      // rd_data_i carries a requested word this cycle
    logic                    en_r;
    logic                    busy_r;
    logic                    done_r;
    logic [`WORD_WIDTH-1:0]  word_r;
    logic                    flush_word_s;

    // A zero word is emitted on every FLUSH edge until FLUSH_LEN have gone out.
    always_comb begin
        flush_word_s = 1'b0;
        if ((state_r == FLUSH) && (flush_cnt_r != FLUSH_LAST)) begin
            flush_word_s = 1'b1;
        end else begin
            flush_word_s = 1'b0;
        end
    end

    // Transfer sequencing: command accept, read-address generation, flush count, completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            remain_r    <= LEN_ZERO;
            flush_cnt_r <= CNT_ZERO;
            rd_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start_i) begin
                        busy_r <= 1'b1;
                        if (bus.len_i == LEN_ZERO) begin
                            // Empty block: report completion right away, no reads.
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            rd_en_r  <= 1'b1;
                            addr_r   <= bus.base_addr_i;
                            remain_r <= bus.len_i - LEN_ONE;
                            state_r  <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (remain_r == LEN_ZERO) begin
                        rd_en_r <= 1'b0;
                        state_r <= DRAIN;
                    end else begin
                        // Address wraps naturally at the buffer size.
                        addr_r   <= addr_r + ADDR_ONE;
                        remain_r <= remain_r - LEN_ONE;
                    end
                end
                DRAIN: begin
                    // The last read's data is captured on this edge.
                    if (valid_r) begin
                        flush_cnt_r <= CNT_ZERO;
                        state_r     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_r == FLUSH_LAST) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    // done_o is high for exactly this one cycle; start is not seen here.
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Data path: valid pipe tracks read latency; word_o is zero whenever en_o is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= 1'b0;
            en_r    <= 1'b0;
            word_r  <= {`WORD_WIDTH{1'b0}};
        end else begin
            valid_r <= rd_en_r;
            if (valid_r) begin
                word_r <= bus.rd_data_i;
                en_r   <= 1'b1;
            end else if (flush_word_s) begin
                word_r <= {`WORD_WIDTH{1'b0}};
                en_r   <= 1'b1;
            end else begin
                word_r <= {`WORD_WIDTH{1'b0}};
                en_r   <= 1'b0;
            end
        end
    end

    assign bus.rd_en_o   = rd_en_r;
    assign bus.rd_addr_o = addr_r;
    assign bus.word_o    = word_r;
    assign bus.en_o      = en_r;
    assign bus.busy_o    = busy_r;
    assign bus.done_o    = done_r;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Bench for systolic_input_feeder: a buffer model serves reads, and every
// cycle of each transfer is compared with the timeline computed from (base, L).
`ifndef WORD_WIDTH
`define WORD_WIDTH 64
`endif

module tb_systolic_input_feeder;
    localparam int AW    = 8;
    localparam int FLUSH = 7;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [63:0] mem [DEPTH];

    systolic_input_feeder_if #(.ADDR_WIDTH(AW)) bus ();

    systolic_input_feeder #(.ADDR_WIDTH(AW), .FLUSH_LEN(FLUSH)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read operand buffer.
    always @(posedge clk) begin
        if (bus.rd_en_o) begin
            bus.rd_data_i <= mem[bus.rd_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " rd_en"},   64'(bus.rd_en_o),   64'd0);
        chk({tag, " rd_addr"}, 64'(bus.rd_addr_o), 64'd0);
        chk({tag, " en"},      64'(bus.en_o),      64'd0);
        chk({tag, " word"},    64'(bus.word_o),    64'd0);
        chk({tag, " busy"},    64'(bus.busy_o),    64'd0);
        chk({tag, " done"},    64'(bus.done_o),    64'd0);
    endtask

    // Present a start in the current cycle (cycle 0) and check cycles 1..last+tail.
    // inject_at: cycle in which a second, random start is presented (0 = none).
    // abort_at: cycle in which reset is pulsed mid-cycle (0 = none).
    task automatic run_xfer(input string name, input int base, input int len,
                            input int inject_at, input int tail, input int abort_at);
        int last;
        logic e_rd, e_en, e_busy, e_done;
        logic [63:0] e_word;
        string tag;
        last = (len == 0) ? 1 : len + 3 + FLUSH;
        bus.start_i     = 1'b1;
        bus.base_addr_i = base[AW-1:0];
        bus.len_i       = len[AW:0];
        for (int c = 1; c <= last + tail; c++) begin
            @(posedge clk);
            #1;
            bus.start_i = (c == inject_at);
            if (c == inject_at) begin
                bus.base_addr_i = AW'($urandom);
                bus.len_i       = (AW+1)'($urandom_range(0, DEPTH));
            end
            e_rd   = (len > 0) && (c <= len);
            e_en   = (len > 0) && (c >= 3) && (c <= len + 2 + FLUSH);
            e_word = (e_en && (c <= len + 2)) ? mem[(base + c - 3) % DEPTH] : 64'd0;
            e_busy = (len > 0) ? (c <= len + 2 + FLUSH) : (c == 1);
            e_done = (len > 0) ? (c == len + 3 + FLUSH) : (c == 1);
            tag = $sformatf("%s c%0d", name, c);
            chk({tag, " rd_en"}, 64'(bus.rd_en_o), 64'(e_rd));
            if (e_rd) chk({tag, " rd_addr"}, 64'(bus.rd_addr_o), 64'((base + c - 1) % DEPTH));
            chk({tag, " en"},   64'(bus.en_o),   64'(e_en));
            chk({tag, " word"}, bus.word_o,      e_word);
            chk({tag, " busy"}, 64'(bus.busy_o), 64'(e_busy));
            chk({tag, " done"}, 64'(bus.done_o), 64'(e_done));
            if (c == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk_quiet({tag, " async-rst"});
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk);
                    #1;
                    chk_quiet($sformatf("%s held-rst%0d", name, k));
                end
                #2;
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.base_addr_i = '0;
        bus.len_i       = '0;
        bus.rd_data_i   = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        for (int k = 0; k < 8; k++) mem[16 + k] = 64'h0101010101010101 * 64'(k + 1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_quiet("post-reset idle");

        // Basic run, then one with an ignored start in cycle 5.
        run_xfer("basic", 16'h10, 8, 0, 1, 0);
        run_xfer("ignored-start", 16'h10, 8, 5, 1, 0);
        // Start presented in the done cycle is ignored; the following run
        // starts in the cycle after an idle check.
        run_xfer("done-cycle-start", 16'h10, 8, 8 + 3 + FLUSH, 1, 0);
        run_xfer("single", 16'hFF, 1, 0, 1, 0);
        run_xfer("wrap", 16'hFE, 4, 0, 1, 0);
        run_xfer("zero-len", 16'h00, 0, 0, 2, 0);
        run_xfer("zero-len-ign", 16'h33, 0, 1, 1, 0);
        run_xfer("full", 16'h00, DEPTH, 0, 1, 0);

        // Reset in cycle 6, then a fresh basic run with no stale words.
        run_xfer("reset-mid", 16'h10, 8, 0, 0, 6);
        @(posedge clk);
        #1;
        run_xfer("after-reset", 16'h10, 8, 0, 1, 0);

        // Randomized transfers with fresh buffer content and a stray start.
        for (int r = 0; r < 8; r++) begin
            int b;
            int l;
            int last;
            for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
            b    = $urandom_range(0, DEPTH - 1);
            l    = $urandom_range(0, 40);
            last = (l == 0) ? 1 : l + 3 + FLUSH;
            run_xfer($sformatf("rand%0d", r), b, l, $urandom_range(1, last), 1, 0);
        end

        bus.start_i = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
